syscall_io_unit: RTL
====================

Name: syscall_io_unit

Overview:
- Responder to the CPU controller's SYSCALL handshake (runio/iobusy).
- Latches the syscall code from ACC and the argument from DR, then runs the call over byte-stream host channels: HALT, READ word, WRITE word.
- Returns a result word plus a one-cycle ACC write strobe to the datapath.
- Sits between the controller/datapath and the host byte link (UART or testbench FIFO).

Parameters:
- WIDTH, 16, machine word width; must be a multiple of 8; NB = WIDTH/8 bytes per word.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- runio  in  1  syscall request from controller; level, held until iobusy seen low
- acc_in  in  WIDTH  ACC value, the syscall code
- dr_in  in  WIDTH  DR value, the argument for WRITE
- iobusy  out  1  combinational busy flag back to controller
- io_result  out  WIDTH  word to ACC mux (selacc IO input)
- io_acc_write  out  1  one-cycle strobe: datapath loads io_result into ACC
- halted  out  1  sticky, set by HALT syscall
- tx_data  out  8  outgoing byte
- tx_valid  out  1  outgoing byte valid
- tx_ready  in  1  host accepts byte
- rx_data  in  8  incoming byte
- rx_valid  in  1  incoming byte valid
- rx_ready  out  1  unit accepts byte

Behaviour:
- Reset (asynchronous, reset=0) clears everything immediately:
  - state=IDLE, halted=0, io_result=0, io_acc_write=0, tx_valid=0, rx_ready=0
  - byte counter=0, latched code and argument = 0
  - Applies mid-transfer too; a partial word is discarded.
- States: IDLE, RX, TX, DONE, HALT.
- iobusy (combinational):
  - 1 in RX, TX and HALT, and in IDLE while runio=1.
  - 0 in DONE, and in IDLE while runio=0.
  - Must be high in the same cycle runio first rises, because the controller samples it on the next edge.
- IDLE with runio=1: latch acc_in to code and dr_in to arg, clear the byte counter, then branch on code (full-width compare):
  - 0 → HALT: halted<=1.
  - 1 → RX.
  - 2 → TX.
  - any other value → DONE: io_result unchanged, no strobe.
- RX:
  - rx_ready=1.
  - On rx_valid&rx_ready, store rx_data into byte [counter] of the shift register, little-endian (first byte → bits 7:0).
  - After byte NB-1: io_result<=assembled word, io_acc_write<=1 for exactly one cycle, go to DONE.
- TX:
  - tx_valid=1, tx_data = arg byte [counter], little-endian.
  - On tx_valid&tx_ready advance the counter; after byte NB-1 go to DONE.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
- DONE:
  - iobusy=0; wait for runio=0, then go to IDLE.
  - Must not restart while runio is still high; the controller drops runio one cycle after seeing iobusy=0.
- HALT: terminal until reset; iobusy=1 permanently, stalling the controller in IOWAIT.
- Handshakes:
  - rx_ready=0 and tx_valid=0 outside RX and TX respectively.
  - Bytes arriving outside RX are not consumed.
  - A stall of any length on valid/ready is legal; no timeout.
- Latency with the host always ready (WIDTH=16):
  - WRITE: runio seen (IDLE) → 2 TX cycles → DONE; iobusy low 3 cycles after runio rise.
  - READ: same count. io_acc_write is high during the first DONE cycle, which is the cycle the controller sees iobusy=0, so ACC loads on that edge.
- io_result holds its value between syscalls; it changes only on READ completion.
- Simultaneous runio edge and reset: reset wins.

Test Plan:
- Reset with runio=0 → iobusy=0, halted=0, tx_valid=0, rx_ready=0, io_result=0.
- WRITE: acc_in=2, dr_in=16'hBEEF, runio=1, tx_ready=1 → tx bytes EF then BE on consecutive cycles. iobusy drops after the 2nd byte and stays low until runio falls; no third byte. Repeat with tx_ready stalled 5 cycles per byte → data stable, same bytes.
- READ: acc_in=1, host sends 34 then 12 with rx_valid gaps → io_result=16'h1234, io_acc_write high exactly one cycle, coincident with iobusy=0.
- HALT: acc_in=0, runio=1 → halted=1, iobusy stays 1 for 100 cycles; rx/tx idle; reset low → halted=0, iobusy=0.
- Unknown code acc_in=7 → iobusy low the next cycle, no strobe, io_result unchanged from prior READ (16'h1234).
- Reset asserted after first READ byte → immediate IDLE. Then a new READ with bytes 01,00 → io_result=16'h0001 (no stale byte).

Source files
------------

// File: rtl/syscall_io_unit.sv
// syscall_io_unit: answers the controller's SYSCALL handshake and runs HALT/READ/WRITE
// over little-endian byte-stream host channels.
module syscall_io_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             runio,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] dr_in,
    output logic             iobusy,
    output logic [WIDTH-1:0] io_result,
    output logic             io_acc_write,
    output logic             halted,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready
);
    localparam int NB = WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {IDLE, RX, TX, DONE, HALT} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NB-1:0][7:0]    arg_q, arg_d;
    logic [NB-1:0][7:0]    sh_q, sh_d;
    logic [WIDTH-1:0]      res_q, res_d;
    logic                  accw_q, accw_d;
    logic                  halted_q, halted_d;
    logic                  last;

    assign last = cnt_q == CW'(NB - 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        arg_d    = arg_q;
        sh_d     = sh_q;
        res_d    = res_q;
        accw_d   = 1'b0;
        halted_d = halted_q;
        case (state_q)
            IDLE: if (runio) begin
                arg_d    = dr_in;
                cnt_d    = '0;
                halted_d = halted_q | (acc_in == '0);
                state_d  = (acc_in == '0)          ? HALT :
                           (acc_in == WIDTH'(1))   ? RX   :
                           (acc_in == WIDTH'(2))   ? TX   : DONE;
            end
            RX: if (rx_valid) begin
                sh_d[cnt_q] = rx_data;
                cnt_d       = cnt_q + CW'(1);
                if (last) begin
                    res_d   = sh_d;
                    accw_d  = 1'b1;
                    state_d = DONE;
                end
            end
            TX: if (tx_ready) begin
                cnt_d   = cnt_q + CW'(1);
                state_d = last ? DONE : TX;
            end
            DONE:    state_d = runio ? DONE : IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            arg_q    <= '0;
            sh_q     <= '0;
            res_q    <= '0;
            accw_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            arg_q    <= arg_d;
            sh_q     <= sh_d;
            res_q    <= res_d;
            accw_q   <= accw_d;
            halted_q <= halted_d;
        end
    end

    // iobusy must rise combinationally with runio so the controller sees it on the next edge
    assign iobusy       = (state_q == RX) || (state_q == TX) || (state_q == HALT) ||
                          ((state_q == IDLE) && runio);
    assign io_result    = res_q;
    assign io_acc_write = accw_q;
    assign halted       = halted_q;
    assign tx_valid     = state_q == TX;
    assign tx_data      = arg_q[cnt_q];
    assign rx_ready     = state_q == RX;
endmodule
